// File: rtl/projb_pkg.sv
// Shared types and widths for the instruction-memory path: the loader FSM state
// encoding and the address/instruction widths that the processor also uses.
package projb_pkg;

    localparam int IMEM_ADDR_W = 7;
    localparam int INSTR_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Switch-entry instruction loader: one word per key strobe, written sequentially into
// instruction memory over a ready/enable handshake. Optional macro: LOADER_CHECKSUM_EN.
module imem_loader
    import projb_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              strobe_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              finish_i,
    input  logic              wr_ready_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   count_o,
    output logic [DATA_W-1:0] checksum_o,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    loader_state_t     state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic              fin_pend_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              close_d;

    assign count_d = count_q + 1'b1;
    // A handshake closes the session on the last slot or on any Finish seen so far.
    assign close_d = (count_d == DEPTH_C) || fin_pend_q || finish_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            fin_pend_q <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= ARMED;
                        busy_q     <= 1'b1;
                        addr_q     <= start_addr_i;
                        count_q    <= '0;
                        done_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        fin_pend_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (strobe_i) begin
                        state_q    <= WRITE;
                        data_q     <= data_in_i;
                        wr_en_q    <= 1'b1;
                        fin_pend_q <= finish_i;
                    end else if (finish_i) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (strobe_i) begin
                        ovf_q <= 1'b1;
                    end
                    if (wr_ready_i) begin
                        wr_en_q <= 1'b0;
                        addr_q  <= addr_q + 1'b1;
                        count_q <= count_d;
                        if (close_d) begin
                            state_q    <= DONE;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            fin_pend_q <= 1'b0;
                        end else begin
                            state_q <= ARMED;
                        end
                    end else if (finish_i) begin
                        fin_pend_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && start_i) begin
            sum_q <= '0;
        end else if (state_q == WRITE && wr_ready_i) begin
            sum_q <= sum_q + data_q;
        end
    end
    assign checksum_o = sum_q;
`else
    assign checksum_o = '0;
`endif

    assign wr_en_o    = wr_en_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign count_o    = count_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-depth instance plus a DEPTH=4 instance
// sharing the same stimulus; memory writes of the main instance are logged on handshake.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  start_addr;
    logic        strobe;
    logic [15:0] data_in;
    logic        finish;
    logic        wr_ready;

    logic        wr_en,  wr_en4;
    logic [6:0]  wr_addr, wr_addr4;
    logic [15:0] wr_data, wr_data4;
    logic        busy,   busy4;
    logic        done,   done4;
    logic        ovf,    ovf4;
    logic [7:0]  count,  count4;
    logic [15:0] csum,   csum4;
    logic [1:0]  state,  state4;

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0]  addr_log[$];
    logic [15:0] data_log[$];

    imem_loader dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
        .strobe_i(strobe), .data_in_i(data_in), .finish_i(finish), .wr_ready_i(wr_ready),
        .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy),
        .done_o(done), .overflow_o(ovf), .count_o(count), .checksum_o(csum), .state_o(state)
    );

    imem_loader #(.DEPTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
        .strobe_i(strobe), .data_in_i(data_in), .finish_i(finish), .wr_ready_i(wr_ready),
        .wr_en_o(wr_en4), .wr_addr_o(wr_addr4), .wr_data_o(wr_data4), .busy_o(busy4),
        .done_o(done4), .overflow_o(ovf4), .count_o(count4), .checksum_o(csum4), .state_o(state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            addr_log.push_back(wr_addr);
            data_log.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return 16'h0 & s;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] a);
        start_addr = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    // Strobe one word with WrReady high: WRITE the next cycle, back out one cycle later.
    task automatic do_word(input logic [15:0] d);
        data_in = d;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("word_wren", {31'd0, wr_en}, 32'd1);
        tick();
    endtask

    task automatic check_log(input string tag, input int idx, input logic [6:0] a, input logic [15:0] d);
        if (idx < addr_log.size()) begin
            check({tag, "_addr"}, {25'd0, addr_log[idx]}, {25'd0, a});
            check({tag, "_data"}, {16'd0, data_log[idx]}, {16'd0, d});
        end else begin
            check({tag, "_present"}, addr_log.size(), idx + 1);
        end
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; start_addr = '0; strobe = 1'b0;
        data_in = '0; finish = 1'b0; wr_ready = 1'b1;
        tick();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_outs", {wr_en, busy, done, ovf}, 32'd0);
        check("rst_vals", {wr_addr, wr_data, count}, 32'd0);
        check("rst_csum", {16'd0, csum}, 32'd0);
        rst = 1'b0;
        tick();

        // Three words then Finish
        do_start(7'd0);
        check("t1_armed", {30'd0, state}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        do_word(16'h1234);
        do_word(16'h00FF);
        do_word(16'hA001);
        do_finish();
        check("t1_state", {30'd0, state}, 32'd3);
        check("t1_done", {busy, done}, 32'b01);
        check("t1_count", {24'd0, count}, 32'd3);
        check("t1_csum", {16'd0, csum}, {16'd0, exp_sum(16'hB334)});
        check("t1_nwr", addr_log.size(), 32'd3);
        check_log("t1_w0", 0, 7'd0, 16'h1234);
        check_log("t1_w1", 1, 7'd1, 16'h00FF);
        check_log("t1_w2", 2, 7'd2, 16'hA001);

        // WrReady held low: stable request, overflow on extra strobe
        base = addr_log.size();
        do_start(7'd10);
        wr_ready = 1'b0;
        data_in = 16'h5555;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold", {wr_en, wr_addr, wr_data}, {8'd0, 1'b1, 7'd10, 16'h5555});
            if (i == 1) begin
                data_in = 16'hDEAD;
                strobe = 1'b1;
            end
            tick();
            strobe = 1'b0;
        end
        check("t2_ovf", {31'd0, ovf}, 32'd1);
        check("t2_cnt_hold", {24'd0, count}, 32'd0);
        wr_ready = 1'b1;
        tick();
        check("t2_release", {wr_en, state}, {29'd0, 1'b0, 2'd1});
        check("t2_count", {24'd0, count}, 32'd1);
        check("t2_nwr", addr_log.size(), base + 1);
        check_log("t2_w", base, 7'd10, 16'h5555);
        do_start(7'd50);
        check("t2_start_ign", {25'd0, wr_addr}, 32'd11);
        do_finish();
        check("t2_done", {30'd0, state}, 32'd3);
        do_start(7'd126);
        check("t2_ovf_clr", {31'd0, ovf}, 32'd0);

        // Address wrap, and auto-close on the DEPTH=4 instance
        base = addr_log.size();
        do_word(16'h0001);
        do_word(16'h0002);
        do_word(16'h0003);
        check_log("t3_w0", base, 7'd126, 16'h0001);
        check_log("t3_w1", base + 1, 7'd127, 16'h0002);
        check_log("t3_w2", base + 2, 7'd0, 16'h0003);
        check("t3_addr", {25'd0, wr_addr}, 32'd1);
        check("t3_csum", {16'd0, csum}, {16'd0, exp_sum(16'h0006)});
        check("t3_d4_armed", {30'd0, state4}, 32'd1);
        do_word(16'h0004);
        check("t3_d4_state", {30'd0, state4}, 32'd3);
        check("t3_d4_done", {busy4, done4}, 32'b01);
        check("t3_d4_count", {24'd0, count4}, 32'd4);
        check("t3_main_armed", {30'd0, state}, 32'd1);
        check("t3_main_count", {24'd0, count}, 32'd4);
        do_finish();

        // Strobe with Finish in the same ARMED cycle, then Finish alone
        base = addr_log.size();
        do_start(7'd0);
        data_in = 16'h0F0F;
        strobe = 1'b1;
        finish = 1'b1;
        tick();
        strobe = 1'b0;
        finish = 1'b0;
        check("t4_write", {30'd0, state}, 32'd2);
        tick();
        check("t4_done", {30'd0, state}, 32'd3);
        check("t4_count", {24'd0, count}, 32'd1);
        check_log("t4_w", base, 7'd0, 16'h0F0F);
        do_start(7'd5);
        do_finish();
        check("t4_fin_state", {done, state}, {29'd0, 1'b1, 2'd3});
        check("t4_fin_count", {24'd0, count}, 32'd0);

        // Asynchronous reset in the middle of a write
        do_start(7'd20);
        wr_ready = 1'b0;
        data_in = 16'hBEEF;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("t5_wren", {31'd0, wr_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_outs", {state, wr_en, busy, done, ovf}, 32'd0);
        check("t5_rst_vals", {wr_addr, wr_data, count}, 32'd0);
        check("t5_rst_csum", {16'd0, csum}, 32'd0);
        tick();
        rst = 1'b0;
        wr_ready = 1'b1;
        tick();
        check("t5_idle", {30'd0, state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
